// File: rtl/tk_lfsr_stepper.sv
// Tweakey-lane LFSR stepper for the Skinny-128-384 tweakey schedule.
// A request carries a lane of LANE_BYTES bytes, a direction (LFSR2 forward
// or LFSR3 inverse) and a step count. The lane is advanced by up to
// STEPS_PER_CYCLE steps per clock until the count is used up. The result is
// then held until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and out_data stays stable until the edge that sees out_ready high.
module tk_lfsr_stepper #(
    parameter int LANE_BYTES      = 16,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int CNT_W           = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*LANE_BYTES-1:0] in_data,
    input  logic                    in_mode,
    input  logic [CNT_W-1:0]        in_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*LANE_BYTES-1:0] out_data,
    output logic                    busy
);

    localparam int LW = 8 * LANE_BYTES;

    // The unrolled step chain only supports these widths.
    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4)) begin : g_bad_steps
            $error("tk_lfsr_stepper: STEPS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [LW-1:0]    lane_q, lane_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic [CNT_W-1:0] k;
    logic             mode_q, mode_nxt;
    logic [LW-1:0]    chain [0:STEPS_PER_CYCLE];

    // One LFSR step on every byte of the lane. The bytes step in parallel.
    // mode 0: LFSR2 {x6..x0, x7^x5}. mode 1: LFSR3 {x0^x6, x7..x1}.
    // LFSR3 undoes LFSR2, and 0x00 is a fixed point of both.
    function automatic logic [LW-1:0] lane_step(input logic [LW-1:0] v, input logic mode);
        logic [LW-1:0] r;
        logic [7:0]    b;
        r = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            b = v[8*i +: 8];
            if (mode) begin
                r[8*i +: 8] = {b[0] ^ b[6], b[7:1]};
            end else begin
                r[8*i +: 8] = {b[6:0], b[7] ^ b[5]};
            end
        end
        return r;
    endfunction

    // Unrolled k-step chain. Stage j steps the lane only if j < remaining.
    // This lets the last partial cycle apply fewer than STEPS_PER_CYCLE steps.
    always_comb begin
        chain[0] = lane_q;
        for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
            if (j < int'({1'b0, rem_q})) begin
                chain[j+1] = lane_step(chain[j], mode_q);
            end else begin
                chain[j+1] = chain[j];
            end
        end
    end

    // Steps consumed this cycle: min(STEPS_PER_CYCLE, remaining).
    always_comb begin
        if (int'({1'b0, rem_q}) < STEPS_PER_CYCLE) begin
            k = rem_q;
        end else begin
            k = CNT_W'(STEPS_PER_CYCLE);
        end
    end

    // State, lane, remaining count and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lane_q <= '0;
            rem_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            lane_q <= lane_nxt;
            rem_q  <= rem_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Next-state and handshake logic. The request inputs are looked at only
    // in IDLE.
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane_q;
        rem_nxt   = rem_q;
        mode_nxt  = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lane_nxt  = in_data;
                    mode_nxt  = in_mode;
                    rem_nxt   = in_count;
                    state_nxt = (in_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                lane_nxt = chain[STEPS_PER_CYCLE];
                rem_nxt  = rem_q - k;
                if (rem_q == k) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_data = lane_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tk_lfsr_stepper.sv
// Directed and randomised checks of tk_lfsr_stepper. Three instances run
// side by side with STEPS_PER_CYCLE = 1, 2 and 4. Inputs are driven 1 ns
// after each rising edge, and outputs are sampled at the same point.
module tb_tk_lfsr_stepper;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_mode   [3];
    logic [5:0]   in_count  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
        $fatal(1, "watchdog");
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            tk_lfsr_stepper #(
                .LANE_BYTES(16),
                .STEPS_PER_CYCLE(1 << g),
                .CNT_W(6)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (in_valid[g]),
                .in_ready (in_ready[g]),
                .in_data  (in_data[g]),
                .in_mode  (in_mode[g]),
                .in_count (in_count[g]),
                .out_valid(out_valid[g]),
                .out_ready(out_ready[g]),
                .out_data (out_data[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    // Reference model: per-byte software LFSR applied n times.
    function automatic logic [127:0] model(input logic [127:0] x, input logic mode, input int n);
        logic [127:0] v;
        logic [7:0]   b;
        v = x;
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 16; i++) begin
                b = v[8*i +: 8];
                v[8*i +: 8] = mode ? {b[0] ^ b[6], b[7:1]} : {b[6:0], b[7] ^ b[5]};
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: send one request to instance d, wait for the result and hold
    // the result for `stall` cycles. Then take it and confirm the return to IDLE.
    task automatic do_req(input int d, input logic [127:0] data, input logic mode,
                          input logic [5:0] cnt, input int stall,
                          output logic [127:0] res, output int lat);
        int s;
        s = 1 << d;
        check("idle_in_ready", 128'(in_ready[d]), 128'(1));
        in_data[d]  = data;
        in_mode[d]  = mode;
        in_count[d] = cnt;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
        in_mode[d]  = ~mode;
        in_count[d] = 6'($urandom_range(0, 63));
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'((int'(cnt) + s - 1) / s));
        res = out_data[d];
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check("back_to_idle", 128'(in_ready[d]), 128'(1));
    endtask

    initial begin
        logic [127:0] r, r1, x, y, z, hold;
        int           lat, d, c, st;
        logic         m;

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_mode[i]   = 1'b0;
            in_count[i]  = '0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b0;

        // Reset values
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 128'(in_ready[i]), 128'(1));
            check("rst_out_valid", 128'(out_valid[i]), 128'(0));
            check("rst_busy", 128'(busy[i]), 128'(0));
            check("rst_out_data", out_data[i], 128'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-byte vectors, S=1, count 1
        do_req(0, 128'h80, 1'b0, 6'd1, 0, r, lat); check("lfsr2_80", r, 128'h01);
        do_req(0, 128'h01, 1'b0, 6'd1, 0, r, lat); check("lfsr2_01", r, 128'h02);
        do_req(0, 128'hA0, 1'b0, 6'd1, 0, r, lat); check("lfsr2_a0", r, 128'h40);
        do_req(0, 128'h01, 1'b1, 6'd1, 0, r, lat); check("lfsr3_01", r, 128'h80);
        do_req(0, 128'h40, 1'b1, 6'd1, 0, r, lat); check("lfsr3_40", r, 128'hA0);

        // Round trip with each STEPS_PER_CYCLE
        x = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            do_req(i, x, 1'b0, 6'd20, 0, y, lat);
            check("fwd20", y, model(x, 1'b0, 20));
            do_req(i, y, 1'b1, 6'd20, 0, z, lat);
            check("roundtrip", z, x);
        end

        // Partial last cycle: S=4, count 5, two edges. Result matches S=1.
        x = {$urandom, $urandom, $urandom, $urandom};
        do_req(0, x, 1'b0, 6'd5, 0, r1, lat);
        do_req(2, x, 1'b0, 6'd5, 0, r, lat);
        check("s4_lat5", 128'(lat), 128'(2));
        check("s4_vs_s1", r, r1);

        // Count 0: result is the input, valid right after accept
        x = {$urandom, $urandom, $urandom, $urandom};
        do_req(1, x, 1'b1, 6'd0, 0, r, lat);
        check("cnt0_lat", 128'(lat), 128'(0));
        check("cnt0_data", r, x);

        // Backpressure in DONE with a competing request present
        x = {$urandom, $urandom, $urandom, $urandom};
        in_data[1] = x; in_mode[1] = 1'b0; in_count[1] = 6'd7; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 128'(lat), 128'(4));
        hold = out_data[1];
        check("bp_data", hold, model(x, 1'b0, 7));
        in_data[1] = ~x; in_mode[1] = 1'b1; in_count[1] = 6'd0; in_valid[1] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_valid", 128'(out_valid[1]), 128'(1));
            check("bp_hold", out_data[1], hold);
            check("bp_in_ready", 128'(in_ready[1]), 128'(0));
        end
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b0;
        check("bp_idle_ready", 128'(in_ready[1]), 128'(1));
        check("bp_valid_drop", 128'(out_valid[1]), 128'(0));
        @(posedge clk); #1;
        check("bp_no_accept", 128'(busy[1]), 128'(0));

        // Reset mid-run
        x = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        in_data[0] = x; in_mode[0] = 1'b0; in_count[0] = 6'd40; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 128'(busy[0]), 128'(1));
        check("mid_data", out_data[0], model(x, 1'b0, 10));
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", out_data[0], 128'(0));
        check("arst_busy", 128'(busy[0]), 128'(0));
        check("arst_valid", 128'(out_valid[0]), 128'(0));
        check("arst_ready", 128'(in_ready[0]), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(0, 128'h0, 1'b0, 6'd63, 0, r, lat);
        check("zero63_lat", 128'(lat), 128'(63));
        check("zero63_data", r, 128'(0));

        // Random requests against the model
        for (int n = 0; n < 1000; n++) begin
            d  = $urandom_range(0, 2);
            x  = {$urandom, $urandom, $urandom, $urandom};
            m  = 1'($urandom_range(0, 1));
            c  = $urandom_range(0, 63);
            st = $urandom_range(0, 3);
            do_req(d, x, m, 6'(c), st, r, lat);
            check("rand_model", r, model(x, m, c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
